// File: rtl/icache_line_fetch.sv
// I-cache refill engine: takes a line-address miss, issues one burst read,
// assembles the returned beats into a full line and pulses it back.
module icache_line_fetch #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    localparam int OFFSET_WIDTH = $clog2(DATA_WIDTH * BLOCK_SIZE / 8),
    localparam int CACHE_WIDTH  = BLOCK_SIZE * DATA_WIDTH,
    localparam int CNT_WIDTH    = $clog2(BLOCK_SIZE)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] ADDR_TO_L2,
    input  logic                           ADDR_TO_L2_VALID,
    output logic [CACHE_WIDTH-1:0]         DATA_FROM_L2,
    output logic                           DATA_FROM_L2_VALID,
    output logic                           BUSY,
    output logic                           ERR,
    output logic [ADDR_WIDTH-1:0]          MEM_ARADDR,
    output logic [7:0]                     MEM_ARLEN,
    output logic                           MEM_ARVALID,
    input  logic                           MEM_ARREADY,
    input  logic [DATA_WIDTH-1:0]          MEM_RDATA,
    input  logic                           MEM_RVALID,
    input  logic                           MEM_RLAST
);

    typedef enum logic [1:0] {IDLE, REQ, BEAT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CACHE_WIDTH-1:0]  line_q, line_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    last_beat;

    assign last_beat = (cnt_q == CNT_WIDTH'(BLOCK_SIZE - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (ADDR_TO_L2_VALID) begin
                    araddr_d  = {ADDR_TO_L2, {OFFSET_WIDTH{1'b0}}};
                    cnt_d     = '0;
                    arvalid_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ADDR_TO_L2_VALID) err_d = 1'b1;
                if (MEM_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = BEAT;
                end
            end
            BEAT: begin
                if (ADDR_TO_L2_VALID) err_d = 1'b1;
                if (MEM_RVALID) begin
                    line_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = MEM_RDATA;
                    // RLAST is only audited; the counter alone ends the burst
                    if (MEM_RLAST != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (ADDR_TO_L2_VALID) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            line_q    <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign DATA_FROM_L2       = line_q;
    assign DATA_FROM_L2_VALID = valid_q;
    assign BUSY               = busy_q;
    assign ERR                = err_q;
    assign MEM_ARADDR         = araddr_q;
    assign MEM_ARLEN          = 8'(BLOCK_SIZE - 1);
    assign MEM_ARVALID        = arvalid_q;

endmodule

// File: tb/tb_icache_line_fetch.sv
// Self-checking bench for icache_line_fetch: directed and randomized refills
// compared every cycle against a transaction-level model of the refill protocol.
module tb_icache_line_fetch;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 32;
    localparam int OW = 7;
    localparam int CW = BS * DW;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [AW-OW-1:0]    ADDR_TO_L2 = '0;
    logic                ADDR_TO_L2_VALID = 1'b0;
    logic [CW-1:0]       DATA_FROM_L2;
    logic                DATA_FROM_L2_VALID;
    logic                BUSY;
    logic                ERR;
    logic [AW-1:0]       MEM_ARADDR;
    logic [7:0]          MEM_ARLEN;
    logic                MEM_ARVALID;
    logic                MEM_ARREADY = 1'b0;
    logic [DW-1:0]       MEM_RDATA = '0;
    logic                MEM_RVALID = 1'b0;
    logic                MEM_RLAST = 1'b0;

    icache_line_fetch dut (
        .CLK(CLK), .RST(RST),
        .ADDR_TO_L2(ADDR_TO_L2), .ADDR_TO_L2_VALID(ADDR_TO_L2_VALID),
        .DATA_FROM_L2(DATA_FROM_L2), .DATA_FROM_L2_VALID(DATA_FROM_L2_VALID),
        .BUSY(BUSY), .ERR(ERR),
        .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN), .MEM_ARVALID(MEM_ARVALID),
        .MEM_ARREADY(MEM_ARREADY), .MEM_RDATA(MEM_RDATA),
        .MEM_RVALID(MEM_RVALID), .MEM_RLAST(MEM_RLAST)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulses = 0;
    int last_lat = 0;
    logic [AW-1:0] last_araddr = '0;

    // Model: what the outputs must be, tracked per transaction
    bit            m_ready = 0;
    bit            m_busy = 0, m_arvalid = 0, m_valid = 0, m_err = 0;
    logic [AW-1:0] m_araddr = '0;
    logic [DW-1:0] m_line [BS];
    int            m_beats = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        int bad;
        check("valid", 32'(DATA_FROM_L2_VALID), 32'(m_valid));
        check("arvalid", 32'(MEM_ARVALID), 32'(m_arvalid));
        check("busy", 32'(BUSY), 32'(m_busy));
        check("err", 32'(ERR), 32'(m_err));
        check("araddr", MEM_ARADDR, m_araddr);
        check("arlen", 32'(MEM_ARLEN), 32'd31);
        bad = -1;
        for (int i = BS - 1; i >= 0; i--)
            if (DATA_FROM_L2[i*DW +: DW] !== m_line[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL line_word%0d: got %h expected %h (cycle %0d)",
                     bad, DATA_FROM_L2[bad*DW +: DW], m_line[bad], cyc);
        end
        if (DATA_FROM_L2_VALID === 1'b1) pulses++;
    endtask

    task automatic advance_model();
        if (RST) begin
            m_busy = 0; m_arvalid = 0; m_valid = 0; m_err = 0;
            m_araddr = '0; m_beats = 0;
            for (int i = 0; i < BS; i++) m_line[i] = '0;
            m_ready = 1;
        end else if (m_valid) begin
            if (ADDR_TO_L2_VALID) m_err = 1;
            m_valid = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (ADDR_TO_L2_VALID) begin
                m_busy = 1; m_arvalid = 1; m_beats = 0;
                m_araddr = {ADDR_TO_L2, 7'b0};
            end
        end else begin
            if (ADDR_TO_L2_VALID) m_err = 1;
            if (m_arvalid) begin
                if (MEM_ARREADY) m_arvalid = 0;
            end else if (MEM_RVALID) begin
                m_line[m_beats] = MEM_RDATA;
                if (MEM_RLAST != (m_beats == BS - 1)) m_err = 1;
                m_beats++;
                if (m_beats == BS) m_valid = 1;
            end
        end
    endtask

    // One clock: compare at the falling edge, fold in the inputs the DUT will sample
    task automatic tick();
        @(negedge CLK);
        if (m_ready) compare_outputs();
        advance_model();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle_junk(input int n);
        repeat (n) begin
            MEM_RVALID = 1'($urandom);
            MEM_RLAST  = 1'($urandom);
            MEM_RDATA  = $urandom;
            tick();
        end
        MEM_RVALID = 0; MEM_RLAST = 0;
    endtask

    task automatic do_reset();
        RST = 1;
        ADDR_TO_L2 = 25'h1abcde;
        ADDR_TO_L2_VALID = 1;
        idle_junk(2);
        ADDR_TO_L2_VALID = 0;
        RST = 0;
        idle_junk(2);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_err", 32'(ERR), 32'd0);
    endtask

    // vmode: 0 back-to-back, 1 toggling, 2 random. Negative beat indices disable a feature.
    task automatic burst(input logic [AW-OW-1:0] addr, input int ar_delay, input int vmode,
                         input int bad_beat, input int dup_beat, input int rst_beat,
                         input bit rnd_data, input logic [31:0] base);
        int k, guard, p0, t_req;
        logic v;
        logic [AW-1:0] a0;
        k = 0; guard = 0; p0 = pulses; t_req = cyc;
        ADDR_TO_L2 = addr;
        ADDR_TO_L2_VALID = 1;
        tick();
        ADDR_TO_L2_VALID = 0;
        ADDR_TO_L2 = 25'($urandom);
        a0 = MEM_ARADDR;
        last_araddr = MEM_ARADDR;
        repeat (ar_delay) begin
            check("arvalid_held", 32'(MEM_ARVALID), 32'd1);
            check("araddr_held", MEM_ARADDR, a0);
            tick();
        end
        check("arvalid_held", 32'(MEM_ARVALID), 32'd1);
        check("araddr_held", MEM_ARADDR, a0);
        MEM_ARREADY = 1;
        tick();
        MEM_ARREADY = 0;
        check("arvalid_drop", 32'(MEM_ARVALID), 32'd0);
        while (k < BS && guard < 1000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            MEM_RVALID = v;
            MEM_RDATA  = rnd_data ? $urandom : base + 32'(k);
            MEM_RLAST  = v && ((k == BS - 1) != (k == bad_beat));
            ADDR_TO_L2_VALID = v && (k == dup_beat);
            RST = v && (k == rst_beat);
            tick();
            ADDR_TO_L2_VALID = 0;
            if (RST) begin
                RST = 0;
                repeat (20) begin
                    MEM_RVALID = 1; MEM_RDATA = $urandom; MEM_RLAST = 1'($urandom);
                    tick();
                end
                break;
            end
            if (v) k++;
            guard++;
        end
        MEM_RVALID = 0; MEM_RLAST = 0;
        check("burst_guard", 32'(guard < 1000), 32'd1);
        last_lat = cyc - t_req;
        if (rst_beat < 0) begin
            check("pulse_after_last", 32'(DATA_FROM_L2_VALID), 32'd1);
            tick(); tick();
            check("one_pulse", 32'(pulses - p0), 32'd1);
        end else begin
            check("no_pulse_after_rst", 32'(pulses - p0), 32'd0);
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_arvalid", 32'(MEM_ARVALID), 32'd0);
        end
    endtask

    initial begin
        bit words_ok;
        for (int i = 0; i < BS; i++) m_line[i] = '0;
        do_reset();

        // Baseline refill with literal expectations on address, latency and contents
        burst(25'h000200, 0, 0, -1, -1, -1, 0, 32'd0);
        check("t1_araddr", last_araddr, 32'h0001_0000);
        check("t1_latency", 32'(last_lat), 32'd34);
        words_ok = 1;
        for (int i = 0; i < BS; i++)
            if (DATA_FROM_L2[i*DW +: DW] !== 32'(i)) words_ok = 0;
        check("t1_word_i_eq_i", 32'(words_ok), 32'd1);
        check("t1_err", 32'(ERR), 32'd0);
        $display("txn 1: baseline line 0x000200 done");

        // Slow address accept and toggling beats
        burst(25'h0abcde, 5, 1, -1, -1, -1, 0, 32'h1000);
        check("t2_err", 32'(ERR), 32'd0);
        $display("txn 2: ARREADY delay 5 with toggling RVALID done");

        // Early RLAST
        burst(25'h000300, 0, 0, 10, -1, -1, 1, 32'd0);
        check("t3_err_sticky", 32'(ERR), 32'd1);
        idle_junk(3);
        check("t3_err_still", 32'(ERR), 32'd1);
        $display("txn 3: early RLAST on beat 10 done");

        // Duplicate request while busy, then recovery after reset
        do_reset();
        burst(25'h000400, 1, 0, -1, 7, -1, 1, 32'd0);
        check("t4_dup_err", 32'(ERR), 32'd1);
        do_reset();
        burst(25'h000401, 0, 0, -1, -1, -1, 1, 32'd0);
        check("t4_recover_err", 32'(ERR), 32'd0);
        $display("txn 4: duplicate request and recovery done");

        // Reset mid-burst then a fresh line
        burst(25'h000500, 0, 0, -1, -1, 15, 1, 32'd0);
        burst(25'h000501, 2, 2, -1, -1, -1, 1, 32'd0);
        check("t5_err", 32'(ERR), 32'd0);
        $display("txn 5: reset at beat 15 then fresh line done");

        // Back-to-back requests
        burst(25'h000200, 0, 0, -1, -1, -1, 0, 32'hA000_0000);
        check("t6_araddr_a", last_araddr, 32'h0001_0000);
        burst(25'h000201, 0, 0, -1, -1, -1, 0, 32'hB000_0000);
        check("t6_araddr_b", last_araddr, 32'h0001_0080);
        check("t6_word31", DATA_FROM_L2[31*DW +: DW], 32'hB000_001F);
        $display("txn 6: sequential lines 0x200/0x201 done");

        // Randomized refills with junk in between
        for (int n = 0; n < 8; n++) begin
            idle_junk($urandom_range(1, 4));
            burst(25'($urandom), $urandom_range(0, 4), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1,
                  -1, -1, 1, 32'd0);
            $display("txn r%0d: random refill done, ERR=%0b", n, ERR);
        end
        idle_junk(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
